paddle_position_ctrl: RTL and testbench

- Consumes the one-cycle move pulses produced by the paddle switch block and maintains one paddle's vertical position on the game grid.
- Position is in board-game units.
- Generates the registered per-cell "draw paddle" signal from the display's column/row scan counts.
- Sits between switch conditioning and the pixel/colour mux; one instance per player.

---
 rtl/game_grid_pkg.sv | 13 +
 rtl/paddle_position_ctrl.sv | 122 ++++++++++++
 tb/tb_paddle_position_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/game_grid_pkg.sv
// Shared game-grid constants and the paddle controller state type.
package game_grid_pkg;

    localparam int unsigned c_GAME_WIDTH  = 40;
    localparam int unsigned c_GAME_HEIGHT = 30;
    localparam int unsigned c_GRID_W      = 6;   // width of the scan counts

    typedef enum logic [0:0] {
        READY,
        HOLD
    } paddle_state_e;

endpackage

// File: rtl/paddle_position_ctrl.sv
// Paddle position controller: tracks one paddle's top row from move pulses and
// produces a registered "draw paddle" flag for the scanned grid cell.
// Optional build macro PADDLE_WRAP_EN: moves past a bound wrap to the other bound
// instead of saturating.
module paddle_position_ctrl
    import game_grid_pkg::*;
#(
    parameter int unsigned c_PADDLE_COL    = 0,
    parameter int unsigned c_GAME_HEIGHT   = game_grid_pkg::c_GAME_HEIGHT,
    parameter int unsigned c_PADDLE_HEIGHT = 6,
    parameter int unsigned c_HOLDOFF       = 0
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Move_Up,
    input  logic                i_Move_Dn,
    input  logic [c_GRID_W-1:0] i_Col_Count,
    input  logic [c_GRID_W-1:0] i_Row_Count,
    output logic [c_GRID_W-1:0] o_Paddle_Y,
    output logic                o_Draw_Paddle,
    output logic                o_At_Top,
    output logic                o_At_Bottom
);

    localparam int unsigned MaxYInt = c_GAME_HEIGHT - c_PADDLE_HEIGHT;
    localparam logic [c_GRID_W-1:0] MaxY     = c_GRID_W'(MaxYInt);
    localparam logic [c_GRID_W-1:0] RstY     = c_GRID_W'(MaxYInt / 2);
    localparam logic [c_GRID_W-1:0] PadLast  = c_GRID_W'(c_PADDLE_HEIGHT - 1);
    localparam logic [c_GRID_W-1:0] PadCol   = c_GRID_W'(c_PADDLE_COL);
    localparam logic [c_GRID_W:0]   GridRows = (c_GRID_W + 1)'(c_GAME_HEIGHT);

    // Counter only needs to hold c_HOLDOFF-1.
    localparam int unsigned CntW = (c_HOLDOFF > 2) ? $clog2(c_HOLDOFF) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((c_HOLDOFF > 0) ? c_HOLDOFF - 1 : 0);

    paddle_state_e       state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [c_GRID_W-1:0] y_q, y_d;
    logic                draw_q, draw_d;
    logic                top_q, bot_q;
    logic                move_ok, up_req, dn_req;
    logic [c_GRID_W:0]   row_ext, pad_bottom;

    // Next position and holdoff FSM; a HOLD cycle whose counter reads 0 already
    // behaves as READY, so exactly c_HOLDOFF cycles are spent in HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        up_req  = i_Move_Up & ~i_Move_Dn;
        dn_req  = i_Move_Dn & ~i_Move_Up;
        move_ok = (state_q == READY) || (cnt_q == '0);

        if (state_q == HOLD) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = READY;
            end
        end

        if (move_ok && (up_req || dn_req)) begin
            if (up_req) begin
                if (y_q != '0) begin
                    y_d = y_q - 1'b1;
                end
`ifdef PADDLE_WRAP_EN
                else begin
                    y_d = MaxY;
                end
`endif
            end else begin
                if (y_q < MaxY) begin
                    y_d = y_q + 1'b1;
                end
`ifdef PADDLE_WRAP_EN
                else begin
                    y_d = '0;
                end
`endif
            end
            // Bound hits still count as accepted moves.
            if (c_HOLDOFF > 0) begin
                state_d = HOLD;
                cnt_d   = CntLoad;
            end
        end
    end

    // Draw decision uses the pre-update position; off-grid rows never draw.
    always_comb begin
        row_ext    = {1'b0, i_Row_Count};
        pad_bottom = {1'b0, y_q} + {1'b0, PadLast};
        draw_d     = (i_Col_Count == PadCol) && (row_ext < GridRows) &&
                     (i_Row_Count >= y_q) && (row_ext <= pad_bottom);
    end

    // State, position and registered flags; reset discards any coincident move.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= READY;
            cnt_q   <= '0;
            y_q     <= RstY;
            draw_q  <= 1'b0;
            top_q   <= (RstY == '0);
            bot_q   <= (RstY == MaxY);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            draw_q  <= draw_d;
            top_q   <= (y_d == '0);
            bot_q   <= (y_d == MaxY);
        end
    end

    assign o_Paddle_Y    = y_q;
    assign o_Draw_Paddle = draw_q;
    assign o_At_Top      = top_q;
    assign o_At_Bottom   = bot_q;

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Bench for paddle_position_ctrl: a default instance and a holdoff-5 instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_paddle_position_ctrl;

    localparam int RSTY = 12;
    localparam int MAXY = 24;
    localparam int PH   = 6;
    localparam int PCOL = 0;
`ifdef PADDLE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, up, dn;
    logic [5:0] col, row;
    logic [5:0] y0, y1;
    logic       draw0, top0, bot0, draw1, top1, bot1;

    int checks = 0;
    int errors = 0;

    // Model state per instance: position, first cycle a move may be taken, draw.
    int hold_len [2] = '{0, 5};
    int m_y      [2];
    int m_next   [2];
    int m_draw   [2];
    int cyc = 0;

    typedef struct {
        bit up;
        bit dn;
        int exp_y0;
        int exp_y1;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    paddle_position_ctrl dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_Move_Up(up), .i_Move_Dn(dn),
        .i_Col_Count(col), .i_Row_Count(row),
        .o_Paddle_Y(y0), .o_Draw_Paddle(draw0), .o_At_Top(top0), .o_At_Bottom(bot0)
    );

    paddle_position_ctrl #(.c_HOLDOFF(5)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Move_Up(up), .i_Move_Dn(dn),
        .i_Col_Count(col), .i_Row_Count(row),
        .o_Paddle_Y(y1), .o_Draw_Paddle(draw1), .o_At_Top(top1), .o_At_Bottom(bot1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs and compare both instances.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_y[k]    = RSTY;
                m_draw[k] = 0;
                m_next[k] = cyc + 1;
            end else begin
                m_draw[k] = (int'(col) == PCOL && int'(row) < 30 &&
                             int'(row) >= m_y[k] && int'(row) <= m_y[k] + PH - 1) ? 1 : 0;
                if (up != dn && cyc >= m_next[k]) begin
                    if (up) m_y[k] = (m_y[k] > 0) ? m_y[k] - 1 : (WRAP ? MAXY : 0);
                    else    m_y[k] = (m_y[k] < MAXY) ? m_y[k] + 1 : (WRAP ? 0 : MAXY);
                    m_next[k] = cyc + hold_len[k];
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        chk("model_y0", int'(y0), m_y[0]);
        chk("model_draw0", int'(draw0), m_draw[0]);
        chk("model_top0", int'(top0), (m_y[0] == 0) ? 1 : 0);
        chk("model_bot0", int'(bot0), (m_y[0] == MAXY) ? 1 : 0);
        chk("model_y1", int'(y1), m_y[1]);
        chk("model_draw1", int'(draw1), m_draw[1]);
        chk("model_top1", int'(top1), (m_y[1] == 0) ? 1 : 0);
        chk("model_bot1", int'(bot1), (m_y[1] == MAXY) ? 1 : 0);
    endtask

    task automatic drive(input bit u, input bit d, input int c, input int r);
        up  = u;
        dn  = d;
        col = 6'(c);
        row = 6'(r);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        rst = 1'b0;
    endtask

    initial begin
        int ey;
        tbl[0] = '{1'b1, 1'b1, 12, 12};
        tbl[1] = '{1'b0, 1'b1, 13, 13};
        tbl[2] = '{1'b0, 1'b0, 13, 13};
        tbl[3] = '{1'b0, 1'b0, 13, 13};
        tbl[4] = '{1'b0, 1'b1, 14, 13};
        tbl[5] = '{1'b0, 1'b0, 14, 13};
        tbl[6] = '{1'b0, 1'b1, 15, 14};
        tbl[7] = '{1'b1, 1'b0, 14, 14};

        rst = 1'b1; up = 1'b0; dn = 1'b0; col = '0; row = '0;

        // Reset state
        do_reset();
        chk("rst_y", int'(y0), 12);
        chk("rst_draw", int'(draw0), 0);
        chk("rst_top", int'(top0), 0);
        chk("rst_bot", int'(bot0), 0);

        // Simultaneous pulses and holdoff window
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].up, tbl[i].dn, 1, 0);
            chk($sformatf("tbl%0d_y0", i), int'(y0), tbl[i].exp_y0);
            chk($sformatf("tbl%0d_y1", i), int'(y1), tbl[i].exp_y1);
        end

        // Up pulses into the top bound, then down pulses into the bottom bound
        do_reset();
        ey = RSTY;
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 1, 0);
            ey = (ey > 0) ? ey - 1 : (WRAP ? MAXY : 0);
            chk("clamp_up_y", int'(y0), ey);
            for (int j = 0; j < 3; j++) drive(0, 0, 1, 0);
        end
        chk("clamp_top", int'(top0), (ey == 0) ? 1 : 0);
        for (int i = 0; i < 30; i++) begin
            drive(0, 1, 1, 0);
            ey = (ey < MAXY) ? ey + 1 : (WRAP ? 0 : MAXY);
            chk("clamp_dn_y", int'(y0), ey);
            for (int j = 0; j < 3; j++) drive(0, 0, 1, 0);
        end
        chk("clamp_bot", int'(bot0), (ey == MAXY) ? 1 : 0);

        // Draw window sweep at Y=12
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 30; r++) begin
                drive(0, 0, c, r);
                chk($sformatf("draw_c%0d_r%0d", c, r), int'(draw0),
                    (c == 0 && r >= 12 && r <= 17) ? 1 : 0);
            end
        end

        // Reset in HOLD with a coincident move pulse
        do_reset();
        drive(0, 1, 1, 0);
        chk("hold_y1", int'(y1), 13);
        rst = 1'b1;
        drive(0, 1, 1, 0);
        rst = 1'b0;
        chk("rst_hold_y1", int'(y1), 12);
        drive(0, 1, 1, 0);
        chk("post_rst_y1", int'(y1), 13);

`ifdef PADDLE_WRAP_EN
        do_reset();
        for (int i = 0; i < 12; i++) drive(1, 0, 1, 0);
        chk("wrap_pre_y0", int'(y0), 0);
        drive(1, 0, 1, 0);
        chk("wrap_up_y0", int'(y0), 24);
        drive(0, 1, 1, 0);
        chk("wrap_dn_y0", int'(y0), 0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2), $urandom_range(0, 40));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
